// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sequences word-lane load/store requests from the core's data port onto a
// single-port synchronous data SRAM. Each request is latched in IDLE, optionally
// delayed by WAIT_CYCLES wait states, issued to the SRAM for exactly one cycle
// and completed with a one-cycle done pulse (plus error for rejected accesses).
// All outputs are registered; they are computed from the next state so that the
// SRAM strobes are high exactly while the FSM is in ACCESS and done/error are
// high exactly while it is in RESP.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to reject out-of-range
// addresses, misaligned addresses and illegal strobe patterns. Without it only
// a simultaneous read+write request is rejected.
//
// Parameters:
//   WAIT_CYCLES  wait states before each SRAM access (0..15)
//   MEM_AW       SRAM word-address width
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   address[31:0]            core byte address (bits [1:0] not used for indexing)
//   read_enable/write_enable request direction, held by the core until done
//   byte_enables[3:0]        lane strobes
//   write_data[31:0]         lane-aligned store data
//   read_data[31:0]          word from the last successful load
//   done, error              completion pulse, rejection pulse (with done)
//   mem_en, mem_we           SRAM access strobe and write enable
//   mem_addr[MEM_AW-1:0]     SRAM word address
//   mem_wstrb[3:0]           SRAM byte write strobes
//   mem_wdata[31:0]          SRAM write data
//   mem_rdata[31:0]          SRAM read data (valid the cycle after a read)
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int WAIT_CYCLES = 0,
  parameter int MEM_AW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [3:0]        byte_enables,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              done,
  output logic              error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter value on entry to WAIT; it counts down to zero inclusive, giving
  // exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef DMEM_RANGE_CHECK_EN
  // Strobe patterns the core can legally generate: single bytes, aligned
  // halfwords, full word, and the empty store.
  function automatic logic strobe_legal(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Address must fall inside the SRAM and be word aligned.
  function automatic logic address_legal(input logic [31:0] a);
    logic ok;
    if (((a >> (MEM_AW + 2)) != 32'd0) || (a[1:0] != 2'b00)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction
`endif

  // Registered state and latched request
  state_t              state_r;
  logic [3:0]          cnt_r;
  logic [MEM_AW-1:0]   addr_r;
  logic [3:0]          be_r;
  logic [31:0]         wdata_r;
  logic                is_write_r;
  logic                rejected_r;

  // Registered outputs
  logic [31:0]         read_data_r;
  logic                done_r;
  logic                error_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [MEM_AW-1:0]   mem_addr_r;
  logic [3:0]          mem_wstrb_r;
  logic [31:0]         mem_wdata_r;

  // Next-state values
  state_t              state_s;
  logic [3:0]          cnt_s;
  logic [MEM_AW-1:0]   addr_s;
  logic [3:0]          be_s;
  logic [31:0]         wdata_s;
  logic                is_write_s;
  logic                rejected_s;
  logic [31:0]         read_data_s;
  logic                done_s;
  logic                error_s;
  logic                mem_en_s;
  logic                mem_we_s;
  logic [MEM_AW-1:0]   mem_addr_s;
  logic [3:0]          mem_wstrb_s;
  logic [31:0]         mem_wdata_s;

  logic                req_s;
  logic                reject_now_s;

  assign req_s = read_enable | write_enable;

`ifdef DMEM_RANGE_CHECK_EN
  // Rejection decision for the request currently presented by the core.
  always_comb begin
    reject_now_s = (read_enable & write_enable)
                 | ~address_legal(address)
                 | ~strobe_legal(byte_enables);
  end
`else
  // Without range checking the upper and alignment address bits are dropped.
  logic unused_addr_s;
  assign unused_addr_s = ^{address[31:MEM_AW+2], address[1:0]};

  // Rejection decision for the request currently presented by the core.
  always_comb begin
    reject_now_s = read_enable & write_enable;
  end
`endif

  // Next-state logic; outputs are derived from the next state so that they
  // register in alignment with the state they belong to.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    addr_s      = addr_r;
    be_s        = be_r;
    wdata_s     = wdata_r;
    is_write_s  = is_write_r;
    rejected_s  = rejected_r;
    read_data_s = read_data_r;
    done_s      = 1'b0;
    error_s     = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wstrb_s = 4'b0000;
    mem_wdata_s = 32'h0000_0000;

    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          addr_s     = address[MEM_AW+1:2];
          be_s       = byte_enables;
          wdata_s    = write_data;
          is_write_s = write_enable;
          rejected_s = reject_now_s;
          cnt_s      = WAIT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_ACCESS;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = S_ACCESS;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_ACCESS: begin
        state_s = S_RESP;
      end
      S_RESP: begin
        state_s = S_IDLE;
        // The SRAM presents the word during RESP; capture it as RESP ends.
        if (!rejected_r && !is_write_r) begin
          read_data_s = mem_rdata;
        end else begin
          read_data_s = read_data_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // SRAM side is driven only in ACCESS, and never for a rejected access.
    if ((state_s == S_ACCESS) && !rejected_s) begin
      mem_en_s   = 1'b1;
      mem_we_s   = is_write_s;
      mem_addr_s = addr_s;
      if (is_write_s) begin
        mem_wstrb_s = be_s;
        mem_wdata_s = wdata_s;
      end else begin
        mem_wstrb_s = 4'b0000;
        mem_wdata_s = 32'h0000_0000;
      end
    end else begin
      mem_en_s = 1'b0;
    end

    if (state_s == S_RESP) begin
      done_s  = 1'b1;
      error_s = rejected_s;
    end else begin
      done_s = 1'b0;
    end
  end

  // State, request latch and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= '0;
      be_r        <= 4'b0000;
      wdata_r     <= 32'h0000_0000;
      is_write_r  <= 1'b0;
      rejected_r  <= 1'b0;
      read_data_r <= 32'h0000_0000;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wstrb_r <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      be_r        <= be_s;
      wdata_r     <= wdata_s;
      is_write_r  <= is_write_s;
      rejected_r  <= rejected_s;
      read_data_r <= read_data_s;
      done_r      <= done_s;
      error_r     <= error_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wstrb_r <= mem_wstrb_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign read_data = read_data_r;
  assign done      = done_r;
  assign error     = error_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for dmem_access_ctrl. Three instances (WAIT_CYCLES = 0, 3, 5) each
// drive their own behavioural SRAM. A table of transactions with hand-computed
// results runs on the zero-wait instance; hand-written sequences cover wait
// state timing, a held request and reset during WAIT.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam int NI = 3;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [15:0] maddr;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst          [NI];
  logic [31:0] address      [NI];
  logic        read_enable  [NI];
  logic        write_enable [NI];
  logic [3:0]  byte_enables [NI];
  logic [31:0] write_data   [NI];
  logic [31:0] read_data    [NI];
  logic        done         [NI];
  logic        error        [NI];
  logic        mem_en       [NI];
  logic        mem_we       [NI];
  logic [15:0] mem_addr     [NI];
  logic [3:0]  mem_wstrb    [NI];
  logic [31:0] mem_wdata    [NI];
  logic [31:0] mem_rdata    [NI];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    logic [31:0] mem [65536];
    logic [31:0] rdata_q;

    dmem_access_ctrl #(.WAIT_CYCLES(W), .MEM_AW(16)) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .address      (address[g]),
      .read_enable  (read_enable[g]),
      .write_enable (write_enable[g]),
      .byte_enables (byte_enables[g]),
      .write_data   (write_data[g]),
      .read_data    (read_data[g]),
      .done         (done[g]),
      .error        (error[g]),
      .mem_en       (mem_en[g]),
      .mem_we       (mem_we[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wstrb    (mem_wstrb[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata[g])
    );

    initial begin
      for (int j = 0; j < 65536; j++) mem[j] <= 32'h0;
      mem[16] <= 32'h600D_F00D;
      rdata_q <= 32'h0;
    end

    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end else begin
          rdata_q <= mem[mem_addr[g]];
        end
      end
    end

    assign mem_rdata[g] = rdata_q;
  end

  function automatic int wait_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 3 : 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access; starts #1 after an edge with the DUT in IDLE and
  // returns #1 after the edge on which the DUT is back in IDLE.
  task automatic run_txn(input int g, input txn_t t);
    int w;
    w = wait_of(g);
    read_enable[g]  = t.rd;
    write_enable[g] = t.wr;
    address[g]      = t.addr;
    byte_enables[g] = t.be;
    write_data[g]   = t.wdata;
    step();  // acceptance edge
    // Disturb the data inputs; the DUT must use its latched copy.
    address[g]      = ~t.addr;
    byte_enables[g] = ~t.be;
    write_data[g]   = ~t.wdata;
    for (int k = 0; k < w; k++) begin
      check("wait_mem_en", mem_en[g], 1'b0);
      check("wait_done", done[g], 1'b0);
      step();
    end
    check("acc_mem_en", mem_en[g], !t.err);
    check("acc_mem_we", mem_we[g], t.wr && !t.err);
    check("acc_mem_addr", {16'h0, mem_addr[g]}, {16'h0, t.maddr});
    check("acc_mem_wstrb", mem_wstrb[g], (t.wr && !t.err) ? t.be : 4'b0000);
    check("acc_mem_wdata", mem_wdata[g], (t.wr && !t.err) ? t.wdata : 32'h0);
    check("acc_done", done[g], 1'b0);
    step();
    check("resp_done", done[g], 1'b1);
    check("resp_error", error[g], t.err);
    check("resp_mem_en", mem_en[g], 1'b0);
    read_enable[g]  = 1'b0;
    write_enable[g] = 1'b0;
    step();
    check("idle_done", done[g], 1'b0);
    check("idle_error", error[g], 1'b0);
    check("read_data", read_data[g], t.rdata);
  endtask

  task automatic check_all_zero(input int g, input string tag);
    check({tag, "_read_data"}, read_data[g], 32'h0);
    check({tag, "_done"}, done[g], 1'b0);
    check({tag, "_error"}, error[g], 1'b0);
    check({tag, "_mem_en"}, mem_en[g], 1'b0);
    check({tag, "_mem_we"}, mem_we[g], 1'b0);
    check({tag, "_mem_addr"}, {16'h0, mem_addr[g]}, 32'h0);
    check({tag, "_mem_wstrb"}, mem_wstrb[g], 4'b0000);
    check({tag, "_mem_wdata"}, mem_wdata[g], 32'h0);
  endtask

  txn_t vec [13];
  txn_t t;
  bit   seen;

  initial begin
    //         rd    wr    addr          be       wdata          err   rdata after                        maddr
    vec[0]  = '{1'b0, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0,                            16'h0040};
    vec[1]  = '{1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF,                    16'h0040};
    vec[2]  = '{1'b0, 1'b1, 32'h0000_0100, 4'b0100, 32'h00AA_0000, 1'b0, 32'hDEAD_BEEF,                    16'h0040};
    vec[3]  = '{1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         1'b0, 32'hDEAA_BEEF,                    16'h0040};
    vec[4]  = '{1'b0, 1'b1, 32'h0004_0000, 4'b1111, 32'h1234_5678, RC,   32'hDEAA_BEEF,                    16'h0000};
    vec[5]  = '{1'b1, 1'b0, 32'h0000_0000, 4'b1111, 32'h0,         1'b0, RC ? 32'h0 : 32'h1234_5678,       16'h0000};
    vec[6]  = '{1'b0, 1'b1, 32'h0000_0104, 4'b0110, 32'hCAFE_F00D, RC,   RC ? 32'h0 : 32'h1234_5678,       RC ? 16'h0 : 16'h0041};
    vec[7]  = '{1'b1, 1'b0, 32'h0000_0104, 4'b1111, 32'h0,         1'b0, RC ? 32'h0 : 32'h00FE_F000,       16'h0041};
    vec[8]  = '{1'b1, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         1'b1, RC ? 32'h0 : 32'h00FE_F000,       16'h0000};
    vec[9]  = '{1'b0, 1'b1, 32'h0000_0108, 4'b0000, 32'hFFFF_FFFF, 1'b0, RC ? 32'h0 : 32'h00FE_F000,       16'h0042};
    vec[10] = '{1'b1, 1'b0, 32'h0000_0108, 4'b1111, 32'h0,         1'b0, 32'h0,                            16'h0042};
    vec[11] = '{1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         1'b0, 32'hDEAA_BEEF,                    16'h0040};
    vec[12] = '{1'b1, 1'b0, 32'h0000_0102, 4'b1111, 32'h0,         RC,   32'hDEAA_BEEF,                    RC ? 16'h0 : 16'h0040};

    for (int g = 0; g < NI; g++) begin
      rst[g]          = 1'b1;
      address[g]      = 32'h0;
      read_enable[g]  = 1'b0;
      write_enable[g] = 1'b0;
      byte_enables[g] = 4'b0000;
      write_data[g]   = 32'h0;
    end
    step();
    step();
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    for (int g = 0; g < NI; g++) check_all_zero(g, "reset");

    // Table of accesses on the zero-wait instance
    for (int i = 0; i < 13; i++) run_txn(0, vec[i]);

    // Request held past done is taken as a new access 3 cycles later
    read_enable[0]  = 1'b1;
    address[0]      = 32'h0000_0100;
    byte_enables[0] = 4'b1111;
    step();
    check("held_first_access", mem_en[0], 1'b1);
    step();
    check("held_first_done", done[0], 1'b1);
    step();
    check("held_gap_done", done[0], 1'b0);
    step();
    check("held_second_access", mem_en[0], 1'b1);
    check("held_second_nodone", done[0], 1'b0);
    step();
    check("held_second_done", done[0], 1'b1);
    read_enable[0] = 1'b0;
    step();
    check("held_idle_done", done[0], 1'b0);
    check("held_read_data", read_data[0], 32'hDEAA_BEEF);

    // Wait-state timing on WAIT_CYCLES=3
    t = '{1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0,         1'b0, 32'h600D_F00D, 16'h0010};
    run_txn(1, t);
    t = '{1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'h1234_ABCD, 1'b0, 32'h600D_F00D, 16'h0011};
    run_txn(1, t);
    t = '{1'b1, 1'b0, 32'h0000_0044, 4'b1111, 32'h0,         1'b0, 32'h0000_ABCD, 16'h0011};
    run_txn(1, t);

    // Reset in the second WAIT cycle of a store on WAIT_CYCLES=5
    t = '{1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0, 1'b0, 32'h600D_F00D, 16'h0010};
    run_txn(2, t);
    write_enable[2] = 1'b1;
    address[2]      = 32'h0000_0200;
    byte_enables[2] = 4'b1111;
    write_data[2]   = 32'hAAAA_5555;
    step();  // accepted, first WAIT cycle
    check("rstw_wait1_mem_en", mem_en[2], 1'b0);
    step();  // second WAIT cycle
    rst[2]          = 1'b1;
    write_enable[2] = 1'b0;
    step();
    rst[2] = 1'b0;
    check_all_zero(2, "rstw");
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done[2] || mem_en[2]) seen = 1'b1;
      step();
    end
    check("rstw_no_done_or_access", seen, 1'b0);
    check("rstw_sram_word", gen_dut[2].mem[128], 32'h0);
    run_txn(2, t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller downstream of the RISC-V core's load/store port. It takes the core's word-lane request (address, byte enables, read/write enables, write data) and sequences it onto a single-port synchronous data SRAM of 64K 32-bit words. It inserts a configurable number of wait states and returns a one-cycle completion pulse with read data. It also flags illegal accesses with an error pulse.

## Interface
- `WAIT_CYCLES`, default 0: wait states inserted before each SRAM access. Legal range is 0..15.
- `MEM_AW`, default 16: SRAM word-address width (64K words).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `address` in 32: core byte address. Word-aligned; bits [1:0] are ignored.
- `read_enable` in 1: load request. Held by the core until `done`.
- `write_enable` in 1: store request. Held by the core until `done`.
- `byte_enables` in 4: lane strobes. Bit i selects byte i of `write_data`/SRAM word.
- `write_data` in 32: store data, already lane-aligned.
- `read_data` out 32: SRAM word from the last completed load.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: one-cycle pulse, coincident with `done`, for a rejected access.
- `mem_en` out 1: SRAM access strobe.
- `mem_we` out 1: SRAM write.
- `mem_addr` out MEM_AW: SRAM word address, equal to `address[MEM_AW+1:2]`.
- `mem_wstrb` out 4: SRAM byte write strobes.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data. Valid the cycle after `mem_en` with `mem_we`=0.

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS, RESP.
- **IDLE**
  - Samples the request as `req = read_enable | write_enable`.
  - On `req`, latches `address`, `byte_enables`, `write_data` and the direction into internal registers. All later outputs come from these registers, so input changes after acceptance are ignored.
  - Next state is WAIT if `WAIT_CYCLES`>0, otherwise ACCESS.
- **WAIT**
  - A 4-bit counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - At 0 the FSM moves to ACCESS.
- **ACCESS**
  - `mem_en`=1.
  - For a store: `mem_we`=1 and `mem_wstrb` = latched strobes.
  - For a load: `mem_we`=0 and `mem_wstrb`=0.
  - A rejected access (see Configuration) skips the SRAM: `mem_en` stays 0 this cycle.
  - Next state is RESP.
- **RESP**
  - `done`=1.
  - For a load, `read_data` <= `mem_rdata`.
  - For a store, or for any rejected access, `read_data` keeps its value.
  - `error`=1 if the access was rejected.
  - Next state is IDLE.
- The core must drop its request on the edge where it samples `done`. A request still high in IDLE is treated as a new access.
- `read_enable` and `write_enable` both high is a rejected access. It is rejected even without range checking.
- A store with `byte_enables`=0000 completes normally. `mem_en`=1 and `mem_we`=1 with zero strobes, so no byte changes.
- SRAM-side outputs are 0 in every state except ACCESS.

## Timing
- Reset values:
  - state IDLE.
  - `done`, `error`, `mem_en`, `mem_we` = 0.
  - `mem_wstrb` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `read_data` = 0.
  - wait counter = 0.
- Latency: a request sampled in IDLE at edge N raises `done` during cycle N+2+`WAIT_CYCLES`.
- Throughput: one access per 3+`WAIT_CYCLES` cycles. There is one idle cycle between back-to-back accesses.
- `read_data` updates on the edge that ends RESP and then holds until the next successful load.
- Reset mid-operation:
  - Reset before ACCESS: no SRAM write occurs.
  - Reset during ACCESS: the write commits, since the SRAM samples on the same edge.
  - In both cases `done` is not issued and the FSM returns to IDLE.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined: an access is rejected if any of the following holds.
  - `address[31:MEM_AW+2]` ≠ 0.
  - `address[1:0]` ≠ 0.
  - `byte_enables` is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111, 0000.
- `DMEM_RANGE_CHECK_EN` undefined: no range or strobe check. Upper address bits are truncated, and any strobe pattern passes to `mem_wstrb`. Only the simultaneous read+write case still rejects.

## Test plan
- **Store then load.** `WAIT_CYCLES`=0, store `address`=0x100, `byte_enables`=1111, `write_data`=0xDEADBEEF, then load 0x100.
  - Store: `done` 2 cycles after acceptance, `mem_addr`=0x40, `mem_wstrb`=1111.
  - Load: `read_data`=0xDEADBEEF.
- **Byte store.** `byte_enables`=0100, `write_data`=0x00AA0000 to 0x100 (holding 0xDEADBEEF) -> subsequent load returns 0xDEAABEEF.
- **Wait states.** `WAIT_CYCLES`=3 load -> `mem_en` exactly 4 cycles after acceptance, `done` exactly 5 cycles after, `mem_en` asserted for exactly one cycle.
- **Range check on.** `DMEM_RANGE_CHECK_EN` defined.
  - Store to 0x0004_0000 -> `error`=`done`=1, `mem_en` never asserted, `read_data` unchanged.
  - `byte_enables`=0110 -> `error`=1.
- **Conflict and held request.** `read_enable`=`write_enable`=1 -> `error`=1 with range checking both on and off. A request held high past `done` -> a second `done` 3 cycles later.
- **Reset in WAIT.** `WAIT_CYCLES`=5, reset asserted in the 2nd WAIT cycle during a store -> SRAM word unchanged, `done` never pulses, all outputs 0 the cycle after reset.
